layer_sequencer: RTL
====================

// Module: layer_sequencer
// PURPOSE
//  Table-driven controller for one shared matrix_multiply engine, one shared relu engine and the argmax unit.
//  Replaces one hard-coded FSM state per layer: it walks NUM_LAYERS layers as MM -> RELU, then finishes with
//  MM -> ARGMAX on the last layer. Each step drives the engine dims and a layer index; mm_layer selects the
//  weight/scratch memories. Adds a watchdog, abort, and optional cycle profiling.
// PARAMETERS
//  NUM_LAYERS  4                       layers to run; legal range 1..8
//  DIM_W       10                      width of the n/k/d dimension fields
//  LAYER_N     {10'd10,10'd32,10'd64,10'd64}   packed output widths; layer0 is the LSB field
//  LAYER_K     {10'd32,10'd64,10'd64,10'd784}  packed input widths; layer0 is the LSB field
//  WDOG_W      20                      watchdog counter width; trips when the counter is all ones
// PORTS
//  clk           in   1              system clock
//  resetn        in   1              async active-low reset
//  start         in   1              1-cycle request to run inference; honoured only in IDLE
//  abort         in   1              synchronous abort; effective in any non-IDLE state
//  mm_start      out  1              1-cycle start pulse to the shared matrix_multiply
//  mm_n          out  DIM_W          n for the current layer (m is fixed at 1)
//  mm_k          out  DIM_W          k for the current layer
//  mm_done       in   1              matrix_multiply completion pulse
//  relu_start    out  1              1-cycle start pulse to the shared relu
//  relu_d        out  DIM_W          relu length; equals LAYER_N of the current layer
//  relu_done     in   1              relu completion pulse
//  argmax_start  out  1              1-cycle start pulse to argmax
//  argmax_done   in   1              argmax completion pulse
//  mm_layer      out  3              current layer index; steers the memory muxes
//  busy          out  1              high in every state except IDLE
//  done          out  1              1-cycle pulse when the run completes
//  wdog_err      out  1              sticky timeout flag; cleared by the next accepted start
//  perf_cycles   out  32             cycles from accepted start to done (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: state=IDLE, layer=0, and every output is 0.
//  mm_n, mm_k and relu_d are registered. They update in the same cycle as layer and stay stable until the next layer.
//  FSM:
//   IDLE      on start: layer<=0, wdog_err<=0, go to ISSUE_MM.
//   ISSUE_MM  assert mm_start for 1 cycle, go to WAIT_MM.
//   WAIT_MM   on mm_done: if layer<NUM_LAYERS-1 go to ISSUE_RL, else go to ISSUE_AM.
//   ISSUE_RL  assert relu_start for 1 cycle, go to WAIT_RL.
//   WAIT_RL   on relu_done: layer<=layer+1, go to ISSUE_MM.
//   ISSUE_AM  assert argmax_start for 1 cycle, go to WAIT_AM.
//   WAIT_AM   on argmax_done: go to FIN.
//   FIN       assert done for 1 cycle, go to IDLE.
//  Latency: start to the first mm_start is exactly 1 cycle, because mm_start is asserted in the cycle after start.
//  Every done->start gap is also exactly 1 cycle.
//  Done inputs are sampled only in their matching WAIT state. In any other state they are ignored, including stray pulses.
//  Watchdog: cleared on entry to every WAIT state and increments each WAIT cycle.
//   When it reaches all ones: set wdog_err, go to IDLE, no done pulse.
//   A done input in the trip cycle wins; the watchdog does not fire.
//  abort: next state is IDLE and layer<=0. No done pulse and no start pulses that cycle. wdog_err is unchanged.
//   abort has priority over the done inputs and the watchdog in the same cycle.
//  start while busy: ignored. start together with abort in IDLE: start is accepted.
//  NUM_LAYERS=1: the sequence is ISSUE_MM -> WAIT_MM -> ISSUE_AM; relu is never started.
//  Async reset mid-run: immediate return to IDLE with all outputs 0. Engines are reset by the same resetn.
// CONFIGURATION
//  LAYER_SEQ_PERF_EN defined:
//   A 32-bit counter clears on an accepted start and increments every busy cycle.
//   It saturates at 32'hFFFF_FFFF. Its value is latched into perf_cycles in the FIN cycle.
//   perf_cycles holds that value until the next FIN. Abort and timeout do not update it.
//  LAYER_SEQ_PERF_EN undefined: perf_cycles is tied to 32'd0 and no counter logic is built.
// TESTING
//  T1 Nominal run with default params. Engine models reply done 5 cycles after each start.
//     Expect 4 mm_start with (n,k) = (64,784),(64,64),(32,64),(10,32).
//     Expect 3 relu_start with d = 64,64,32, then 1 argmax_start, then 1 done pulse; busy low afterwards.
//  T2 With PERF_EN, same run as T1. Expect perf_cycles = 57.
//     Count: 8 steps x 1 issue + 8 x 6 wait + 1 FIN.
//  T3 Hold relu_done low in layer 1.
//     Expect wdog_err=1 and IDLE after 2^20-1 WAIT_RL cycles, with no done.
//     A new start then clears wdog_err.
//  T4 Assert abort during WAIT_MM of layer 2, in the same cycle as mm_done.
//     Expect IDLE next cycle, no relu_start and no done.
//     A restart issues mm_k=784.
//  T5 Apply stray relu_done/argmax_done pulses in IDLE and WAIT_MM, and start while busy.
//     Expect the state sequence unchanged from T1.
//  T6 Drop resetn mid-WAIT_RL.
//     Expect all outputs 0 at once; after release, start runs T1 normally.

Source files
------------

// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Table-driven controller for one shared matrix_multiply engine, one shared
// relu engine and the argmax unit. Layers run as MM -> RELU. The last layer
// runs MM -> ARGMAX instead. Per-layer dimensions come from the packed
// LAYER_N / LAYER_K tables, with layer 0 in the least significant field.
//
// Optional feature (macro LAYER_SEQ_PERF_EN):
//   When the macro is defined, a saturating 32-bit busy-cycle counter is built.
//   Its value is latched into o_perf_cycles when a run finishes normally.
//   When the macro is undefined, o_perf_cycles is tied to zero.
//
// Ports:
//   i_clk            system clock
//   i_resetn         asynchronous active-low reset
//   i_start          run request, honoured only while idle
//   i_abort          synchronous abort, effective in any non-idle state
//   o_mm_start       1-cycle start pulse to matrix_multiply
//   o_mm_n, o_mm_k   matrix_multiply dimensions for the current layer
//   i_mm_done        matrix_multiply completion pulse
//   o_relu_start     1-cycle start pulse to relu
//   o_relu_d         relu length (the n of the current layer)
//   i_relu_done      relu completion pulse
//   o_argmax_start   1-cycle start pulse to argmax
//   i_argmax_done    argmax completion pulse
//   o_mm_layer       current layer index, steers the memory muxes
//   o_busy           high in every state except idle
//   o_done           1-cycle pulse when a run completes
//   o_wdog_err       sticky timeout flag, cleared by the next accepted start
//   o_perf_cycles    busy cycles of the last completed run (0 without the macro)
// -----------------------------------------------------------------------------
module layer_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int DIM_W      = 10,
  parameter logic [NUM_LAYERS*DIM_W-1:0] LAYER_N = {10'd10, 10'd32, 10'd64, 10'd64},
  parameter logic [NUM_LAYERS*DIM_W-1:0] LAYER_K = {10'd32, 10'd64, 10'd64, 10'd784},
  parameter int WDOG_W     = 20
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_mm_start,
  output logic [DIM_W-1:0] o_mm_n,
  output logic [DIM_W-1:0] o_mm_k,
  input  logic             i_mm_done,
  output logic             o_relu_start,
  output logic [DIM_W-1:0] o_relu_d,
  input  logic             i_relu_done,
  output logic             o_argmax_start,
  input  logic             i_argmax_done,
  output logic [2:0]       o_mm_layer,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wdog_err,
  output logic [31:0]      o_perf_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_MM,
    S_WAIT_MM,
    S_ISSUE_RL,
    S_WAIT_RL,
    S_ISSUE_AM,
    S_WAIT_AM,
    S_FIN
  } state_t;

  localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);

  state_t              r_state;
  state_t              w_stateNext;
  logic [2:0]          r_layer;
  logic [2:0]          w_layerNext;
  logic                w_layerLoad;
  logic [DIM_W-1:0]    r_mmN;
  logic [DIM_W-1:0]    r_mmK;
  logic [DIM_W-1:0]    r_reluD;
  logic [WDOG_W-1:0]   r_wdogCnt;
  logic                w_wdogTrip;
  logic                w_wdogClr;
  logic                w_inWait;
  logic                r_wdogErr;
  logic                w_wdogErrSet;
  logic                w_accept;

  // Table lookups: the field for layer idx sits at bit idx*DIM_W.
  function automatic logic [DIM_W-1:0] tableN(input logic [2:0] idx);
    tableN = LAYER_N[int'(idx)*DIM_W +: DIM_W];
  endfunction

  function automatic logic [DIM_W-1:0] tableK(input logic [2:0] idx);
    tableK = LAYER_K[int'(idx)*DIM_W +: DIM_W];
  endfunction

  assign w_inWait   = (r_state == S_WAIT_MM) || (r_state == S_WAIT_RL) ||
                      (r_state == S_WAIT_AM);
  assign w_wdogTrip = (r_wdogCnt == {WDOG_W{1'b1}});

  assign o_mm_n     = r_mmN;
  assign o_mm_k     = r_mmK;
  assign o_relu_d   = r_reluD;
  assign o_mm_layer = r_layer;
  assign o_busy     = (r_state != S_IDLE);
  assign o_wdog_err = r_wdogErr;

  // Next-state logic and the start/done pulses.
  // In every WAIT state the engine's done input takes priority over a watchdog
  // trip. A timeout also returns the layer index to 0, so the memory muxes
  // idle on layer 0 just as they do after reset or abort.
  always_comb begin
    w_stateNext    = r_state;
    w_layerNext    = r_layer;
    w_layerLoad    = 1'b0;
    w_accept       = 1'b0;
    w_wdogClr      = 1'b0;
    w_wdogErrSet   = 1'b0;
    o_mm_start     = 1'b0;
    o_relu_start   = 1'b0;
    o_argmax_start = 1'b0;
    o_done         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_layerNext = 3'd0;
          w_layerLoad = 1'b1;
          w_stateNext = S_ISSUE_MM;
        end
      end

      S_ISSUE_MM: begin
        o_mm_start  = 1'b1;
        w_wdogClr   = 1'b1;
        w_stateNext = S_WAIT_MM;
      end

      S_WAIT_MM: begin
        if (i_mm_done) begin
          if (r_layer < LAST_LAYER) begin
            w_stateNext = S_ISSUE_RL;
          end else begin
            w_stateNext = S_ISSUE_AM;
          end
        end else if (w_wdogTrip) begin
          w_wdogErrSet = 1'b1;
          w_layerNext  = 3'd0;
          w_layerLoad  = 1'b1;
          w_stateNext  = S_IDLE;
        end
      end

      S_ISSUE_RL: begin
        o_relu_start = 1'b1;
        w_wdogClr    = 1'b1;
        w_stateNext  = S_WAIT_RL;
      end

      S_WAIT_RL: begin
        if (i_relu_done) begin
          w_layerNext = r_layer + 3'd1;
          w_layerLoad = 1'b1;
          w_stateNext = S_ISSUE_MM;
        end else if (w_wdogTrip) begin
          w_wdogErrSet = 1'b1;
          w_layerNext  = 3'd0;
          w_layerLoad  = 1'b1;
          w_stateNext  = S_IDLE;
        end
      end

      S_ISSUE_AM: begin
        o_argmax_start = 1'b1;
        w_wdogClr      = 1'b1;
        w_stateNext    = S_WAIT_AM;
      end

      S_WAIT_AM: begin
        if (i_argmax_done) begin
          w_stateNext = S_FIN;
        end else if (w_wdogTrip) begin
          w_wdogErrSet = 1'b1;
          w_layerNext  = 3'd0;
          w_layerLoad  = 1'b1;
          w_stateNext  = S_IDLE;
        end
      end

      S_FIN: begin
        o_done      = 1'b1;
        w_stateNext = S_IDLE;
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase

    // Abort overrides everything above, including done inputs and the
    // watchdog, and suppresses any pulse that this cycle would have produced.
    // The sticky error flag is left as it was.
    if (i_abort && (r_state != S_IDLE)) begin
      w_stateNext    = S_IDLE;
      w_layerNext    = 3'd0;
      w_layerLoad    = 1'b1;
      w_wdogErrSet   = 1'b0;
      o_mm_start     = 1'b0;
      o_relu_start   = 1'b0;
      o_argmax_start = 1'b0;
      o_done         = 1'b0;
    end
  end

  // State, layer index and dimension registers. The dimensions reload
  // whenever the layer index does, so they change in the same cycle as
  // o_mm_layer and stay stable for the rest of the layer.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_layer <= 3'd0;
      r_mmN   <= '0;
      r_mmK   <= '0;
      r_reluD <= '0;
    end else begin
      r_state <= w_stateNext;
      r_layer <= w_layerNext;
      if (w_layerLoad) begin
        r_mmN   <= tableN(w_layerNext);
        r_mmK   <= tableK(w_layerNext);
        r_reluD <= tableN(w_layerNext);
      end
    end
  end

  // Watchdog counter: cleared in every ISSUE state, so it reads 0 in the
  // first cycle of the following WAIT state, then counts WAIT cycles.
  // Error flag: set on a trip, cleared only by an accepted start.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wdogCnt <= '0;
      r_wdogErr <= 1'b0;
    end else begin
      if (w_wdogClr) begin
        r_wdogCnt <= '0;
      end else if (w_inWait) begin
        r_wdogCnt <= r_wdogCnt + WDOG_W'(1);
      end

      if (w_accept) begin
        r_wdogErr <= 1'b0;
      end else if (w_wdogErrSet) begin
        r_wdogErr <= 1'b1;
      end
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] r_perfCnt;
  logic [31:0] r_perfOut;
  logic [31:0] w_perfInc;

  assign w_perfInc     = (r_perfCnt == 32'hFFFF_FFFF) ? r_perfCnt : (r_perfCnt + 32'd1);
  assign o_perf_cycles = r_perfOut;

  // The FIN cycle is itself busy, so the latched value is the incremented
  // count. This makes o_perf_cycles equal to the total number of busy cycles
  // in the run. An aborted FIN suppresses o_done, and the latch is skipped too.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_perfCnt <= 32'd0;
      r_perfOut <= 32'd0;
    end else begin
      if (w_accept) begin
        r_perfCnt <= 32'd0;
      end else if (r_state != S_IDLE) begin
        r_perfCnt <= w_perfInc;
      end

      if (o_done) begin
        r_perfOut <= w_perfInc;
      end
    end
  end
`else
  assign o_perf_cycles = 32'd0;
`endif

endmodule
